ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage directly upstream of the Mem stage. Computes ALU result / memory address and registers
//  op, op2, op3, regD and store data towards Mem. SMUL/UMUL/SDIV/UDIV run on an iterative 1-bit/cycle engine.
//  Stalls the decode stage while iterating or while Mem deasserts mem_ready. Bubble = op 00, op2 100, regD 0.
// PARAMETERS
//  XLEN   64  datapath / alures width
//  MD_W   32  mul/div operand width = iteration count
// PORTS
//  clk             in   1     clock, all state on rising edge
//  reset           in   1     reset, asynchronous, active-low (asserted when 0)
//  Ex_valid_in     in   1     upstream presents an instruction
//  Ex_op_in        in   2     op field
//  Ex_op2_in       in   3     op2 field
//  Ex_op3_in       in   6     op3 field
//  Ex_regD_in      in   5     destination register
//  Ex_rs1_in       in   64    operand A
//  Ex_rs2_in       in   64    operand B (immediate already muxed)
//  Ex_valD_in      in   32    store data, passed through
//  mem_ready       in   1     Mem stage can accept a new instruction
//  ex_ready        out  1     this stage accepts Ex_*_in this cycle
//  Ex_alures_out   out  64    result / effective address
//  Ex_regD_out     out  5     registered regD
//  Ex_op_out       out  2     registered op
//  Ex_op2_out      out  3     registered op2
//  Ex_op3_out      out  6     registered op3
//  Ex_valD_out     out  32    registered store data
//  Ex_divzero_out  out  1     result is a divide by zero
// BEHAVIOUR
//  Reset: state IDLE, count 0, bubble on outputs (alures 0, regD 0, op 00, op2 100, op3 0, valD 0, divzero 0).
//   Takes effect immediately. Any operation in progress is discarded.
//  ex_ready = (state==IDLE) && mem_ready. Pure combinational.
//  Accept = Ex_valid_in && ex_ready. Output register loads only when mem_ready=1. With mem_ready=0 all outputs hold.
//  IDLE, accept, single-cycle op: result registered at the next edge (latency 1).
//  IDLE, mem_ready=1, no valid input: load a bubble.
//  Single-cycle results:
//   op 01 (ld/st): rs1+rs2
//   op 00/op2 100 (sethi/nop): rs2
//   op 10, op3 000000 ADD: rs1+rs2
//   op3 000100 SUB: rs1-rs2
//   op3 000001/000010/000011: AND/OR/XOR
//   op3 100101/100110/100111: SLL/SRL/SRA by rs2[5:0]
//   Other op 10 op3 codes: alures 0, fields passed.
//   Adds and subtracts are XLEN-bit, with carry-out dropped.
//  Mul/div (op 10, op3 001010 UMUL, 001011 SMUL, 001110 UDIV, 001111 SDIV): operands rs1[31:0], rs2[31:0].
//   On accept: latch fields and operands (signed ops take magnitudes and record the result sign). Load a bubble.
//   Set count 0, enter BUSY.
//  BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle, count++. At count==MD_W-1 enter DONE.
//  DONE: ex_ready=0.
//   If mem_ready: alures <= result, the latched fields are output, and the state returns to IDLE.
//   Otherwise hold in DONE.
//  Mul/div latency with mem_ready=1: result visible MD_W+1 cycles after the accept edge.
//  Results:
//   MUL: full 64-bit product (negated for SMUL with differing signs).
//   DIV: 32-bit quotient, zero-extended (UDIV) or sign-extended (SDIV, sign = xor of operand signs).
//   Remainder is discarded.
//  SDIV of -2^31 / -1: result 0x0000_0000_8000_0000 (no trap).
//  Divide by zero (rs2[31:0]==0): skip BUSY and go straight to DONE. alures = all ones, Ex_divzero_out=1 with that result.
//   Latency 2.
//  mem_ready dropping during BUSY does not pause iteration. It only delays the DONE->IDLE handoff.
//  Ex_divzero_out is 0 for every other result and for bubbles.
// TESTING
//  ADD: rs1=5, rs2=7, regD=3, mem_ready=1 -> next cycle alures=12, regD=3, op=10, ex_ready stays 1.
//  Stall: mem_ready=0 for 3 cycles with a valid SUB 9-4 -> ex_ready=0, outputs frozen.
//   Release -> alures=5 one cycle later.
//  UMUL: 0xFFFF_FFFF*2 -> ex_ready=0 and bubbles for 33 cycles, then alures=0x0000_0001_FFFF_FFFE.
//  SDIV: -7/2 -> alures=0xFFFF_FFFF_FFFF_FFFD after 33 cycles. SMUL -3*4 -> 0xFFFF_FFFF_FFFF_FFF4.
//  UDIV: 100/0 -> alures=0xFFFF_FFFF_FFFF_FFFF, divzero=1, visible 2 cycles after accept.
//  Reset: reset=0 at BUSY count 10 -> outputs become bubble immediately.
//   After release, ex_ready=1 (mem_ready=1) and a following ADD completes with latency 1.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address generation plus an iterative 1-bit/cycle
// mul/div engine, with a result register that only advances when Mem is ready.
module ex_stage #(
    parameter int XLEN = 64,
    parameter int MD_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Ex_valid_in,
    input  logic [1:0]      Ex_op_in,
    input  logic [2:0]      Ex_op2_in,
    input  logic [5:0]      Ex_op3_in,
    input  logic [4:0]      Ex_regD_in,
    input  logic [XLEN-1:0] Ex_rs1_in,
    input  logic [XLEN-1:0] Ex_rs2_in,
    input  logic [31:0]     Ex_valD_in,
    input  logic            mem_ready,
    output logic            ex_ready,
    output logic [XLEN-1:0] Ex_alures_out,
    output logic [4:0]      Ex_regD_out,
    output logic [1:0]      Ex_op_out,
    output logic [2:0]      Ex_op2_out,
    output logic [5:0]      Ex_op3_out,
    output logic [31:0]     Ex_valD_out,
    output logic            Ex_divzero_out
);
    localparam int CW = $clog2(MD_W);
    localparam int SW = $clog2(XLEN);
    localparam int PW = 2 * MD_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;

    logic            accept, is_md, is_div, is_sgn;
    logic [MD_W-1:0] opa, opb, mag_a, mag_b;
    logic [XLEN-1:0] alu_res, md_res;

    // Engine state: md_a = multiplicand (mul) or divisor (div),
    // md_b = multiplier (mul) or dividend shifting into quotient (div),
    // md_acc = product (mul) or partial remainder (div).
    logic [PW-1:0]   md_a, md_acc;
    logic [MD_W-1:0] md_b;
    logic            md_div, md_neg, md_dz;
    logic [1:0]      l_op;
    logic [2:0]      l_op2;
    logic [5:0]      l_op3;
    logic [4:0]      l_regD;
    logic [31:0]     l_valD;

    assign ex_ready = (state == IDLE) && mem_ready;
    assign accept   = Ex_valid_in && ex_ready;
    assign is_md    = (Ex_op_in == 2'b10) && (Ex_op3_in[5:4] == 2'b00) && Ex_op3_in[3] && Ex_op3_in[1];
    assign is_div   = Ex_op3_in[2];
    assign is_sgn   = Ex_op3_in[0];
    assign opa      = Ex_rs1_in[MD_W-1:0];
    assign opb      = Ex_rs2_in[MD_W-1:0];
    assign mag_a    = (is_sgn && opa[MD_W-1]) ? -opa : opa;
    assign mag_b    = (is_sgn && opb[MD_W-1]) ? -opb : opb;

    always_comb begin
        alu_res = '0;
        case (Ex_op_in)
            2'b01: alu_res = Ex_rs1_in + Ex_rs2_in;
            2'b00: if (Ex_op2_in == 3'b100) alu_res = Ex_rs2_in;
            2'b10: begin
                case (Ex_op3_in)
                    6'b000000: alu_res = Ex_rs1_in + Ex_rs2_in;
                    6'b000100: alu_res = Ex_rs1_in - Ex_rs2_in;
                    6'b000001: alu_res = Ex_rs1_in & Ex_rs2_in;
                    6'b000010: alu_res = Ex_rs1_in | Ex_rs2_in;
                    6'b000011: alu_res = Ex_rs1_in ^ Ex_rs2_in;
                    6'b100101: alu_res = Ex_rs1_in << Ex_rs2_in[SW-1:0];
                    6'b100110: alu_res = Ex_rs1_in >> Ex_rs2_in[SW-1:0];
                    6'b100111: alu_res = $signed(Ex_rs1_in) >>> Ex_rs2_in[SW-1:0];
                    default:   alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Restoring division step
    logic [MD_W:0] rem_sh, rem_sub;
    logic          rem_ge;
    assign rem_sh  = {md_acc[MD_W-1:0], md_b[MD_W-1]};
    assign rem_sub = rem_sh - {1'b0, md_a[MD_W-1:0]};
    assign rem_ge  = rem_sh >= {1'b0, md_a[MD_W-1:0]};

    // A zero quotient stays zero even when the operand signs differ.
    logic [PW-1:0]   prod;
    logic [MD_W-1:0] quo;
    assign prod = md_neg ? -md_acc : md_acc;
    assign quo  = md_neg ? -md_b : md_b;

    always_comb begin
        md_res = XLEN'(prod);
        if (md_dz)       md_res = '1;
        else if (md_div) md_res = {{(XLEN-MD_W){md_neg && (md_b != '0)}}, quo};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && is_md) state_nx = (is_div && (opb == '0)) ? DONE : BUSY;
            BUSY: if (count == CW'(MD_W - 1)) state_nx = DONE;
            DONE: if (mem_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            md_a   <= '0;
            md_b   <= '0;
            md_acc <= '0;
            md_div <= 1'b0;
            md_neg <= 1'b0;
            md_dz  <= 1'b0;
            l_op   <= '0;
            l_op2  <= '0;
            l_op3  <= '0;
            l_regD <= '0;
            l_valD <= '0;
        end else if (accept && is_md) begin
            count  <= '0;
            md_a   <= PW'(is_div ? mag_b : mag_a);
            md_b   <= is_div ? mag_a : mag_b;
            md_acc <= '0;
            md_div <= is_div;
            md_neg <= is_sgn && (opa[MD_W-1] ^ opb[MD_W-1]);
            md_dz  <= is_div && (opb == '0);
            l_op   <= Ex_op_in;
            l_op2  <= Ex_op2_in;
            l_op3  <= Ex_op3_in;
            l_regD <= Ex_regD_in;
            l_valD <= Ex_valD_in;
        end else if (state == BUSY) begin
            count <= count + 1'b1;
            if (md_div) begin
                md_acc <= PW'(rem_ge ? rem_sub[MD_W-1:0] : rem_sh[MD_W-1:0]);
                md_b   <= {md_b[MD_W-2:0], rem_ge};
            end else begin
                if (md_b[0]) md_acc <= md_acc + md_a;
                md_a <= md_a << 1;
                md_b <= md_b >> 1;
            end
        end
    end

    // Output register: frozen whenever Mem is not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Ex_alures_out  <= '0;
            Ex_regD_out    <= '0;
            Ex_op_out      <= 2'b00;
            Ex_op2_out     <= 3'b100;
            Ex_op3_out     <= '0;
            Ex_valD_out    <= '0;
            Ex_divzero_out <= 1'b0;
        end else if (mem_ready) begin
            if (state == DONE) begin
                Ex_alures_out  <= md_res;
                Ex_regD_out    <= l_regD;
                Ex_op_out      <= l_op;
                Ex_op2_out     <= l_op2;
                Ex_op3_out     <= l_op3;
                Ex_valD_out    <= l_valD;
                Ex_divzero_out <= md_dz;
            end else if (accept && !is_md) begin
                Ex_alures_out  <= alu_res;
                Ex_regD_out    <= Ex_regD_in;
                Ex_op_out      <= Ex_op_in;
                Ex_op2_out     <= Ex_op2_in;
                Ex_op3_out     <= Ex_op3_in;
                Ex_valD_out    <= Ex_valD_in;
                Ex_divzero_out <= 1'b0;
            end else begin
                Ex_alures_out  <= '0;
                Ex_regD_out    <= '0;
                Ex_op_out      <= 2'b00;
                Ex_op2_out     <= 3'b100;
                Ex_op3_out     <= '0;
                Ex_valD_out    <= '0;
                Ex_divzero_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push expectations (value + due cycle),
// a negedge monitor pops and compares whenever the output register has loaded a non-bubble.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Ex_valid_in = 1'b0;
    logic [1:0]  Ex_op_in = '0;
    logic [2:0]  Ex_op2_in = '0;
    logic [5:0]  Ex_op3_in = '0;
    logic [4:0]  Ex_regD_in = '0;
    logic [63:0] Ex_rs1_in = '0;
    logic [63:0] Ex_rs2_in = '0;
    logic [31:0] Ex_valD_in = '0;
    logic        mem_ready = 1'b1;
    logic        ex_ready;
    logic [63:0] Ex_alures_out;
    logic [4:0]  Ex_regD_out;
    logic [1:0]  Ex_op_out;
    logic [2:0]  Ex_op2_out;
    logic [5:0]  Ex_op3_out;
    logic [31:0] Ex_valD_out;
    logic        Ex_divzero_out;

    ex_stage dut (
        .clk(clk), .reset(reset), .Ex_valid_in(Ex_valid_in), .Ex_op_in(Ex_op_in),
        .Ex_op2_in(Ex_op2_in), .Ex_op3_in(Ex_op3_in), .Ex_regD_in(Ex_regD_in),
        .Ex_rs1_in(Ex_rs1_in), .Ex_rs2_in(Ex_rs2_in), .Ex_valD_in(Ex_valD_in),
        .mem_ready(mem_ready), .ex_ready(ex_ready), .Ex_alures_out(Ex_alures_out),
        .Ex_regD_out(Ex_regD_out), .Ex_op_out(Ex_op_out), .Ex_op2_out(Ex_op2_out),
        .Ex_op3_out(Ex_op3_out), .Ex_valD_out(Ex_valD_out), .Ex_divzero_out(Ex_divzero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [4:0]  rd;
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [31:0] vd;
        logic        dz;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic ld_q = 1'b0;

    always @(posedge clk) begin
        cyc++;
        ld_q = mem_ready;
    end

    always @(negedge clk) begin
        if (reset && ld_q && !(Ex_op_out == 2'b00 && Ex_op2_out == 3'b100 && Ex_regD_out == 5'd0)) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d alures=%h regD=%0d", cyc, Ex_alures_out, Ex_regD_out);
            end else begin
                m_e = q.pop_front();
                if (Ex_alures_out !== m_e.alu || Ex_regD_out !== m_e.rd || Ex_op_out !== m_e.op ||
                    Ex_op2_out !== m_e.op2 || Ex_op3_out !== m_e.op3 || Ex_valD_out !== m_e.vd ||
                    Ex_divzero_out !== m_e.dz || cyc != m_e.due) begin
                    failures++;
                    $display("FAIL result got alu=%h rd=%0d op=%b op2=%b op3=%b vd=%h dz=%b cyc=%0d want alu=%h rd=%0d op=%b op2=%b op3=%b vd=%h dz=%b cyc=%0d",
                             Ex_alures_out, Ex_regD_out, Ex_op_out, Ex_op2_out, Ex_op3_out, Ex_valD_out, Ex_divzero_out, cyc,
                             m_e.alu, m_e.rd, m_e.op, m_e.op2, m_e.op3, m_e.vd, m_e.dz, m_e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] op2, input logic [5:0] op3,
                         input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b, input logic [31:0] vd);
        Ex_op_in = op; Ex_op2_in = op2; Ex_op3_in = op3; Ex_regD_in = rd;
        Ex_rs1_in = a; Ex_rs2_in = b; Ex_valD_in = vd; Ex_valid_in = 1'b1;
    endtask

    task automatic expect_out(input logic [1:0] op, input logic [2:0] op2, input logic [5:0] op3,
                              input logic [4:0] rd, input logic [31:0] vd, input logic [63:0] res,
                              input logic dz, input int lat);
        exp_t e;
        e = '{res, rd, op, op2, op3, vd, dz, cyc + lat};
        q.push_back(e);
    endtask

    // Called #1 after a rising edge with the stage idle; returns #1 after the stage is idle again.
    task automatic send(input logic [1:0] op, input logic [2:0] op2, input logic [5:0] op3,
                        input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] vd, input logic [63:0] res, input logic dz, input int lat);
        int n;
        chk("ex_ready_idle", 64'(ex_ready), 64'd1);
        drive(op, op2, op3, rd, a, b, vd);
        expect_out(op, op2, op3, rd, vd, res, dz, lat);
        @(posedge clk); #1;
        Ex_valid_in = 1'b0;
        n = 0;
        while (!ex_ready && n < 100) begin
            chk("busy_bubble", {53'd0, Ex_op_out, Ex_op2_out, Ex_regD_out, Ex_divzero_out},
                {53'd0, 2'b00, 3'b100, 5'd0, 1'b0});
            @(posedge clk); #1;
            n++;
        end
        if (!ex_ready) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=0 want=1");
        end
    endtask

    localparam logic [1:0] OP_A = 2'b10;
    localparam logic [2:0] O2 = 3'b000;
    int c0;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alures", Ex_alures_out, 64'd0);
        chk("rst_fields", {52'd0, Ex_op_out, Ex_op2_out, Ex_op3_out, Ex_regD_out},
            {52'd0, 2'b00, 3'b100, 6'd0, 5'd0});
        chk("rst_valD_dz", {31'd0, Ex_valD_out, Ex_divzero_out}, 64'd0);
        chk("rst_ready", 64'(ex_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        send(OP_A, O2, 6'b000000, 5'd3, 64'd5, 64'd7, 32'h0, 64'd12, 1'b0, 1);

        // Stall: SUB presented while Mem is not ready; ADD result must stay put.
        drive(OP_A, O2, 6'b000100, 5'd4, 64'd9, 64'd4, 32'h0);
        mem_ready = 1'b0;
        #1 chk("stall_ready", 64'(ex_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_alures", Ex_alures_out, 64'd12);
            chk("stall_regD", 64'(Ex_regD_out), 64'd3);
        end
        mem_ready = 1'b1;
        expect_out(OP_A, O2, 6'b000100, 5'd4, 32'h0, 64'd5, 1'b0, 1);
        @(posedge clk); #1;
        Ex_valid_in = 1'b0;

        send(OP_A, O2, 6'b000001, 5'd5, 64'hF0F0, 64'hFF00, 32'h1, 64'hF000, 1'b0, 1);
        send(OP_A, O2, 6'b000010, 5'd6, 64'hF0, 64'h0F, 32'h2, 64'hFF, 1'b0, 1);
        send(OP_A, O2, 6'b000011, 5'd7, 64'hFF, 64'h0F, 32'h3, 64'hF0, 1'b0, 1);
        send(OP_A, O2, 6'b100101, 5'd8, 64'd1, 64'd68, 32'h4, 64'd16, 1'b0, 1);
        send(OP_A, O2, 6'b100111, 5'd9, 64'h8000_0000_0000_0000, 64'd4, 32'h5, 64'hF800_0000_0000_0000, 1'b0, 1);
        send(OP_A, O2, 6'b100110, 5'd10, 64'h8000_0000_0000_0000, 64'd4, 32'h6, 64'h0800_0000_0000_0000, 1'b0, 1);
        send(2'b01, 3'b000, 6'b000000, 5'd11, 64'h1000, 64'h20, 32'hDEAD_BEEF, 64'h1020, 1'b0, 1);
        send(2'b00, 3'b100, 6'b000000, 5'd12, 64'hFFFF, 64'h1234_5000, 32'h7, 64'h1234_5000, 1'b0, 1);
        send(OP_A, O2, 6'b000100, 5'd13, 64'd0, 64'd1, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        send(OP_A, O2, 6'b000000, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h9, 64'd0, 1'b0, 1);
        send(OP_A, O2, 6'b111000, 5'd15, 64'd3, 64'd4, 32'hA, 64'd0, 1'b0, 1);

        // Mul/div: result appears 33 cycles after the accept edge.
        send(OP_A, O2, 6'b001010, 5'd16, 64'hAAAA_AAAA_FFFF_FFFF, 64'h5555_5555_0000_0002, 32'hB,
             64'h0000_0001_FFFF_FFFE, 1'b0, 34);
        send(OP_A, O2, 6'b001111, 5'd17, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32'hC,
             64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34);
        send(OP_A, O2, 6'b001011, 5'd18, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 32'hD,
             64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 34);
        send(OP_A, O2, 6'b001110, 5'd19, 64'd100, 64'd0, 32'hE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);
        send(OP_A, O2, 6'b001111, 5'd20, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 32'hF,
             64'h0000_0000_8000_0000, 1'b0, 34);
        send(OP_A, O2, 6'b001110, 5'd21, 64'd100, 64'd7, 32'h10, 64'd14, 1'b0, 34);
        send(OP_A, O2, 6'b001111, 5'd22, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 32'h11,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2);

        // mem_ready low during BUSY: iteration continues, handoff waits for release.
        c0 = cyc;
        drive(OP_A, O2, 6'b001010, 5'd23, 64'd3, 64'd5, 32'h12);
        expect_out(OP_A, O2, 6'b001010, 5'd23, 32'h12, 64'd15, 1'b0, 41);
        @(posedge clk); #1;
        Ex_valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        chk("done_hold_ready", 64'(ex_ready), 64'd0);
        chk("done_hold_cyc", 64'(cyc - c0), 64'd40);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_release_ready", 64'(ex_ready), 64'd1);

        // Reset in the middle of an iteration discards it.
        drive(OP_A, O2, 6'b001010, 5'd24, 64'd9, 64'd9, 32'h13);
        @(posedge clk); #1;
        Ex_valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_fields", {52'd0, Ex_op_out, Ex_op2_out, Ex_op3_out, Ex_regD_out},
            {52'd0, 2'b00, 3'b100, 6'd0, 5'd0});
        chk("mid_rst_alures", Ex_alures_out, 64'd0);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(ex_ready), 64'd1);
        send(OP_A, O2, 6'b000000, 5'd25, 64'd5, 64'd7, 32'h14, 64'd12, 1'b0, 1);

        repeat (50) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
